i2c_reg_target: RTL

I2C target (responder) with an internal byte register file: the other end of the codec configuration bus. It decodes START, device address, register pointer and data bytes from SCL/SDA and commits each written byte to the register file. It ACKs on the open-drain SDA and, when compiled in, serves register reads. It is used as a board-level configuration target and as the codec-side model on the control bus in system simulation, where it receives the `{reg, data}` write sequence issued by the configuration sequencer.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/i2c_reg_target.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding,
// ACK/NACK bit levels and the default 7-bit device address.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // ES8388 codec with CE tied low
  localparam logic [6:0] I2C_DEV_ADDR = 7'h10;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input conditioning: 2-flop synchronizers, one history flop per
// line, and SCL edge / START / STOP detection. Flops reset to 1 (bus idle)
// so no spurious START or STOP is seen when reset is released.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start,
  output logic stop
);

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  // Synchronize both pins and keep one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  // SDA transitions only count as START/STOP while SCL is stable high
  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign sda_s    = sda_s2_q;
  assign start    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with an internal byte register file. Decodes device address,
// register pointer and data bytes, commits written bytes with a wr_en strobe
// and ACKs on open-drain SDA. Register reads over the bus are built only
// when the I2C_TGT_READ_EN macro is defined; otherwise R/W=1 is NACKed.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = I2C_DEV_ADDR,
  parameter int         REG_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);

  localparam int         AW     = $clog2(REG_DEPTH);
  localparam logic [8:0] DEPTH9 = 9'(REG_DEPTH);

  // Pointers at or above REG_DEPTH have no storage behind them
  function automatic logic in_range(input logic [7:0] a);
    return ({1'b0, a} < DEPTH9);
  endfunction

  logic scl_rise, scl_fall, sda_s, start, stop;

  i2c_bus_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .sda_s   (sda_s),
    .start   (start),
    .stop    (stop)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [7:0] ptr_q, ptr_d;
  logic       ack_q, ack_d;       // 1 once the ACK bit slot has begun
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] rd_data_q;
  logic [7:0] rf_q [REG_DEPTH];

  logic [7:0] byte_w;
  logic       byte_done;
  logic       addr_ok;
  logic       dev_ack_bit;

  assign byte_w    = {sh_q, sda_s};
  assign byte_done = scl_rise && (cnt_q == 3'd7);

`ifdef I2C_TGT_READ_EN
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] cur_byte;

  assign addr_ok  = (byte_w[7:1] == DEV_ADDR);
  assign cur_byte = in_range(ptr_q) ? rf_q[ptr_q[AW-1:0]] : 8'h00;
`else
  assign addr_ok  = (byte_w[7:1] == DEV_ADDR) && (byte_w[0] == 1'b0);
`endif

  assign dev_ack_bit = addr_ok ? I2C_ACK : I2C_NACK;

  // Control state, pointer, SDA drive and write strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      ptr_q     <= 8'h00;
      ack_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
`ifdef I2C_TGT_READ_EN
      rw_q      <= 1'b0;
      mack_q    <= I2C_NACK;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef I2C_TGT_READ_EN
      rw_q      <= rw_d;
      mack_q    <= mack_d;
`endif
    end
  end

  // Receive and transmit shift registers carry data only and need no reset
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
`ifdef I2C_TGT_READ_EN
    tx_q <= tx_d;
`endif
  end

  // Next-state logic: START/STOP override everything, then per-state bit handling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    ack_d     = ack_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef I2C_TGT_READ_EN
    rw_d      = rw_q;
    mack_d    = mack_q;
    tx_d      = tx_q;
`endif
    if (start) begin
      state_d  = DEV;
      cnt_d    = 3'd0;
      ack_d    = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      ack_d    = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, IGNORE: sda_oe_d = 1'b0;
        DEV, PTR, WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_w[6:0];
            cnt_d = cnt_q + 3'd1;
          end
          if (byte_done) begin
            ack_d = 1'b0;
            if (state_q == DEV) begin
              state_d = (dev_ack_bit == I2C_ACK) ? DEV_ACK : IGNORE;
`ifdef I2C_TGT_READ_EN
              rw_d    = byte_w[0];
`endif
            end else if (state_q == PTR) begin
              state_d = PTR_ACK;
              ptr_d   = byte_w;
            end else begin
              state_d   = WACK;
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_w;
              ptr_d     = ptr_q + 8'd1;
            end
          end
        end
        DEV_ACK, PTR_ACK, WACK: begin
          // First fall opens the ACK slot, second fall closes it
          if (scl_fall) begin
            if (!ack_q) begin
              ack_d    = 1'b1;
              sda_oe_d = 1'b1;
            end else begin
              ack_d    = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              if (state_q != DEV_ACK) begin
                state_d = WDATA;
              end else begin
`ifdef I2C_TGT_READ_EN
                if (rw_q) begin
                  state_d  = RDATA;
                  tx_d     = cur_byte;
                  sda_oe_d = ~cur_byte[7];
                end else begin
                  state_d = PTR;
                end
`else
                state_d = PTR;
`endif
              end
            end
          end
        end
`ifdef I2C_TGT_READ_EN
        RDATA: begin
          // Next bit is presented on each fall; a 1 bit releases SDA
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
            if (cnt_q == 3'd7) begin
              state_d = RACK;
              ack_d   = 1'b0;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~tx_q[7];
          end
        end
        RACK: begin
          if (scl_fall && !ack_q) begin
            ack_d    = 1'b1;
            sda_oe_d = 1'b0;
          end else if (scl_rise && ack_q) begin
            mack_d = sda_s;
            ptr_d  = ptr_q + 8'd1;
          end else if (scl_fall && ack_q) begin
            ack_d = 1'b0;
            cnt_d = 3'd0;
            if (mack_q == I2C_ACK) begin
              state_d  = RDATA;
              tx_d     = cur_byte;
              sda_oe_d = ~cur_byte[7];
            end else begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end
`endif
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Register file commit (one cycle after the strobe) and registered fabric read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) rf_q[i] <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      if (wr_en_q && in_range(wr_addr_q)) rf_q[wr_addr_q[AW-1:0]] <= wr_data_q;
      rd_data_q <= in_range(rd_addr) ? rf_q[rd_addr[AW-1:0]] : 8'h00;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_data = rd_data_q;
  assign busy    = (state_q != IDLE) && (state_q != IGNORE);

endmodule
